// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the mtm ALU core: opcodes, error-bit positions,
// controller states and the CRC helpers used by the controller, serializer and deserializer.
package mtm_alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    // Positions inside the 3-bit error vector {e_data, e_crc, e_op}
    localparam int ERR_DATA_BIT = 2;
    localparam int ERR_CRC_BIT  = 1;
    localparam int ERR_OP_BIT   = 0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT     = 3'd3,
        ST_EMIT     = 3'd4,
        ST_ERR_EMIT = 3'd5
    } ctrl_state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        logic ok;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: ok = 1'b1;
            default:                       ok = 1'b0;
        endcase
        return ok;
    endfunction

    // x^4+x+1, init 0, MSB first
    function automatic logic [3:0] crc4_d68(input logic [67:0] d);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return c;
    endfunction

    // x^3+x+1, init 0, MSB first
    function automatic logic [2:0] crc3_d37(input logic [36:0] d);
        logic [2:0] c;
        logic       fb;
        c = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb = c[2] ^ d[i];
            c  = {c[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
        end
        return c;
    endfunction

    // Error control byte with trailing even parity over bits [7:1]
    function automatic logic [7:0] err_ctl(input logic [2:0] e);
        logic [6:0] hi;
        hi = {1'b1, e, e};
        return {hi, ^hi};
    endfunction

endpackage

// File: rtl/mtm_alu_ctrl_resp.sv
// Response stage: builds the control byte and holds the output register
// until the serializer accepts it.
module mtm_alu_ctrl_resp
    import mtm_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_ok,
    input  logic        load_err,
    input  logic [2:0]  err_code,
    input  logic [31:0] alu_c,
    input  logic [3:0]  alu_flags,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [7:0]  out_ctl,
    output logic        out_is_err,
    output logic        xfer
);

    logic        out_valid_r;
    logic [31:0] out_data_r;
    logic [7:0]  out_ctl_r;
    logic        out_is_err_r;

    // Output register: load a normal or error response, clear valid on transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= 32'd0;
            out_ctl_r    <= 8'd0;
            out_is_err_r <= 1'b0;
        end else if (load_ok) begin
            out_valid_r  <= 1'b1;
            out_data_r   <= alu_c;
            out_ctl_r    <= {1'b0, alu_flags, crc3_d37({alu_c, 1'b0, alu_flags})};
            out_is_err_r <= 1'b0;
        end else if (load_err) begin
            out_valid_r  <= 1'b1;
            out_data_r   <= 32'd0;
            out_ctl_r    <= err_ctl(err_code);
            out_is_err_r <= 1'b1;
        end else if (out_valid_r && out_ready) begin
            out_valid_r  <= 1'b0;
        end
    end

    assign xfer       = out_valid_r && out_ready;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_ctl    = out_ctl_r;
    assign out_is_err = out_is_err_r;

endmodule

// File: rtl/mtm_alu_ctrl.sv
// Sequencing controller between the frame deserializer and the multi-cycle ALU:
// validates a frame, issues it, watches for timeout and hands the response on.
module mtm_alu_ctrl
    import mtm_alu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frm_valid,
    input  logic [31:0] frm_a,
    input  logic [31:0] frm_b,
    input  logic [7:0]  frm_ctl,
    input  logic        frm_err,
    output logic        busy,
    output logic        alu_start,
    output logic [2:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic        alu_done,
    input  logic [31:0] alu_c,
    input  logic [3:0]  alu_flags,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [7:0]  out_ctl,
    output logic        out_is_err,
    output logic [7:0]  drop_cnt
);

    localparam int CW = $clog2(TIMEOUT + 1);

    ctrl_state_e state_r, state_s;
    logic [31:0] a_r, b_r;
    logic [2:0]  op_r;
    logic [3:0]  crc_r;
    logic        err_r;
    logic [CW-1:0] tmo_cnt_r;
    logic [7:0]  drop_cnt_r;
    logic        busy_r, alu_start_r;
    logic        load_ok_s, load_err_s, xfer_s;
    logic [2:0]  err_s, verdict_s;
    logic        unused_ctl_msb_s;

    assign unused_ctl_msb_s = frm_ctl[7];

    // Frame verdict with priority data error > CRC error > opcode error
    always_comb begin
        verdict_s = 3'b000;
        if (err_r) begin
            verdict_s[ERR_DATA_BIT] = 1'b1;
        end else if (crc4_d68({a_r, b_r, 1'b1, op_r}) != crc_r) begin
            verdict_s[ERR_CRC_BIT] = 1'b1;
        end else if (!op_is_legal(op_r)) begin
            verdict_s[ERR_OP_BIT] = 1'b1;
        end else begin
            verdict_s = 3'b000;
        end
    end

    // Next state and response-load requests
    always_comb begin
        state_s    = state_r;
        load_ok_s  = 1'b0;
        load_err_s = 1'b0;
        err_s      = 3'b000;
        case (state_r)
            ST_IDLE: begin
                if (frm_valid) state_s = ST_CHECK;
                else           state_s = ST_IDLE;
            end
            ST_CHECK: begin
                if (verdict_s != 3'b000) begin
                    state_s    = ST_ERR_EMIT;
                    load_err_s = 1'b1;
                    err_s      = verdict_s;
                end else begin
                    state_s    = ST_ISSUE;
                end
            end
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                // A done coinciding with the last allowed cycle still wins
                if (alu_done) begin
                    state_s   = ST_EMIT;
                    load_ok_s = 1'b1;
                end else if (tmo_cnt_r == CW'(TIMEOUT)) begin
                    state_s           = ST_ERR_EMIT;
                    load_err_s        = 1'b1;
                    err_s[ERR_OP_BIT] = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_EMIT, ST_ERR_EMIT: begin
                if (xfer_s) state_s = ST_IDLE;
                else        state_s = state_r;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, frame latch, issue pulse and timeout counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            a_r         <= 32'd0;
            b_r         <= 32'd0;
            op_r        <= 3'd0;
            crc_r       <= 4'd0;
            err_r       <= 1'b0;
            tmo_cnt_r   <= '0;
            busy_r      <= 1'b0;
            alu_start_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            busy_r      <= (state_s != ST_IDLE);
            alu_start_r <= (state_s == ST_ISSUE);
            if (state_r == ST_IDLE && frm_valid) begin
                a_r   <= frm_a;
                b_r   <= frm_b;
                op_r  <= frm_ctl[6:4];
                crc_r <= frm_ctl[3:0];
                err_r <= frm_err;
            end
            if (state_r == ST_ISSUE) begin
                tmo_cnt_r <= CW'(1);
            end else if (state_r == ST_WAIT && tmo_cnt_r != CW'(TIMEOUT)) begin
                tmo_cnt_r <= tmo_cnt_r + CW'(1);
            end
        end
    end

    // Saturating count of frames arriving while not idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_r <= 8'd0;
        end else if (frm_valid && state_r != ST_IDLE && drop_cnt_r != 8'hFF) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end
    end

    mtm_alu_ctrl_resp u_resp (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_ok    (load_ok_s),
        .load_err   (load_err_s),
        .err_code   (err_s),
        .alu_c      (alu_c),
        .alu_flags  (alu_flags),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ctl    (out_ctl),
        .out_is_err (out_is_err),
        .xfer       (xfer_s)
    );

    assign busy      = busy_r;
    assign alu_start = alu_start_r;
    assign alu_op    = op_r;
    assign alu_a     = a_r;
    assign alu_b     = b_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_mtm_alu_ctrl.sv
// Scoreboard bench for mtm_alu_ctrl: directed corner cases plus random frames,
// with a behavioural ALU and CRC model computed by polynomial division.
module tb_mtm_alu_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frm_valid = 1'b0;
    logic [31:0] frm_a = 32'd0, frm_b = 32'd0;
    logic [7:0]  frm_ctl = 8'd0;
    logic        frm_err = 1'b0;
    logic        busy, alu_start;
    logic [2:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic        alu_done = 1'b0;
    logic [31:0] alu_c = 32'd0;
    logic [3:0]  alu_flags = 4'd0;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_ctl;
    logic        out_is_err;
    logic [7:0]  drop_cnt;

    logic fixed_ready = 1'b1, rand_ready = 1'b0, rnd_ready = 1'b0;
    assign out_ready = rand_ready ? rnd_ready : fixed_ready;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  ctl;
        logic        is_err;
    } resp_t;

    resp_t sb[$];
    int total = 0, bad = 0;
    int cyc = 0, start_cyc = 0, rise_cyc = 0, start_cnt = 0, xfer_cnt = 0;
    int alu_delay = 1;
    bit alu_never = 1'b0;

    mtm_alu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .frm_valid(frm_valid), .frm_a(frm_a), .frm_b(frm_b),
        .frm_ctl(frm_ctl), .frm_err(frm_err), .busy(busy), .alu_start(alu_start),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_done(alu_done), .alu_c(alu_c),
        .alu_flags(alu_flags), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctl(out_ctl), .out_is_err(out_is_err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // CRC as remainder of message * x^n modulo the generator
    function automatic logic [3:0] ref_crc4(input logic [67:0] m);
        logic [71:0] r;
        r = {m, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    function automatic logic [2:0] ref_crc3(input logic [36:0] m);
        logic [39:0] r;
        r = {m, 3'b000};
        for (int i = 39; i >= 3; i--)
            if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
        return r[2:0];
    endfunction

    // Returns {carry, overflow, zero, negative, result}
    function automatic logic [35:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] c;
        logic cy, ov;
        cy = 1'b0; ov = 1'b0; c = 32'd0;
        case (op)
            3'b000: c = a & b;
            3'b001: c = a | b;
            3'b100: begin
                w = {1'b0, a} + {1'b0, b};
                c = w[31:0]; cy = w[32];
                ov = (a[31] == b[31]) && (c[31] != a[31]);
            end
            3'b101: begin
                c = a - b; cy = (a < b);
                ov = (a[31] != b[31]) && (c[31] != a[31]);
            end
            default: c = 32'd0;
        endcase
        return {cy, ov, (c == 32'd0), c[31], c};
    endfunction

    function automatic resp_t ref_resp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                       input bit crc_ok, input bit err, input bit tmo);
        resp_t r;
        logic [2:0] e;
        logic [35:0] fc;
        if (err)                                                   e = 3'b100;
        else if (!crc_ok)                                          e = 3'b010;
        else if (!(op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd5)) e = 3'b001;
        else if (tmo)                                              e = 3'b001;
        else                                                       e = 3'b000;
        if (e != 3'b000) begin
            r.data = 32'd0;
            r.ctl = {1'b1, e, e, 1'b0};
            r.ctl[0] = ($countones(e) * 2 + 1) % 2 == 1;
            r.is_err = 1'b1;
        end else begin
            fc = ref_alu(op, a, b);
            r.data = fc[31:0];
            r.ctl = {1'b0, fc[35:32], ref_crc3({fc[31:0], 1'b0, fc[35:32]})};
            r.is_err = 1'b0;
        end
        return r;
    endfunction

    // Drives one frame for a single cycle; c0 is the cycle in which it is sampled
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input bit crc_ok,
                        input bit err, input bit tmo, input bit expect_resp, output int c0);
        @(posedge clk); #1;
        frm_valid = 1'b1; frm_a = a; frm_b = b; frm_err = err;
        frm_ctl = {1'b0, op, ref_crc4({a, b, 1'b1, op}) ^ (crc_ok ? 4'b0000 : 4'b0001)};
        c0 = cyc;
        if (expect_resp) sb.push_back(ref_resp(a, b, op, crc_ok, err, tmo));
        @(posedge clk); #1;
        frm_valid = 1'b0; frm_err = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin @(negedge clk); n++; end
        if (busy) chk("idle_timeout", busy, 0);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < budget) begin @(negedge clk); n++; end
        if (!out_valid) chk("valid_timeout", out_valid, 1);
    endtask

    // Behavioural multi-cycle ALU
    initial begin
        logic [35:0] r;
        forever begin
            @(negedge clk);
            if (rst_n && alu_start && !alu_never) begin
                r = ref_alu(alu_op, alu_a, alu_b);
                repeat (alu_delay) @(posedge clk);
                #1; alu_done = 1'b1; alu_c = r[31:0]; alu_flags = r[35:32];
                @(posedge clk); #1; alu_done = 1'b0;
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: scoreboard pops on transfer, stall stability, timing marks
    initial begin
        bit stall_prev = 1'b0, prev_valid = 1'b0;
        resp_t held, e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0; prev_valid = 1'b0;
            end else begin
                if (alu_start) begin start_cyc = cyc; start_cnt++; end
                if (out_valid && !prev_valid) rise_cyc = cyc;
                if (stall_prev) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, held.data);
                    chk("stall_ctl", out_ctl, held.ctl);
                    chk("stall_is_err", out_is_err, held.is_err);
                end
                if (out_valid && out_ready) begin
                    xfer_cnt++;
                    if (sb.size() == 0) begin
                        chk("unexpected_xfer", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", out_data, e.data);
                        chk("out_ctl", out_ctl, e.ctl);
                        chk("out_is_err", out_is_err, e.is_err);
                    end
                end
                stall_prev = out_valid && !out_ready;
                held = '{data: out_data, ctl: out_ctl, is_err: out_is_err};
                prev_valid = out_valid;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, s0, x0, nv;
        logic [2:0] op;
        bit good, err, nev, legal;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_start", alu_start, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_out_ctl", out_ctl, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_alu_a", alu_a, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        alu_delay = 1;
        send(32'd1, 32'd2, 3'b100, 1, 0, 0, 1, c0);
        wait_idle(50);
        chk("add_start_cycle", start_cyc - c0, 2);
        chk("add_valid_cycle", rise_cyc - c0, 4);

        alu_delay = 2;
        send(32'd0, 32'd1, 3'b101, 1, 0, 0, 1, c0);
        wait_idle(50);
        chk("crc3_pkg", mtm_alu_pkg::crc3_d37({32'hFFFF_FFFF, 1'b0, 4'b1001}),
            ref_crc3({32'hFFFF_FFFF, 1'b0, 4'b1001}));

        s0 = start_cnt;
        send(32'h1234_5678, 32'h0BAD_F00D, 3'b100, 0, 0, 0, 1, c0);
        wait_idle(50);
        chk("badcrc_valid_cycle", rise_cyc - c0, 2);
        chk("badcrc_no_start", start_cnt - s0, 0);
        send(32'hA5A5_0000, 32'h0000_5A5A, 3'b011, 1, 0, 0, 1, c0);
        wait_idle(50);
        send(32'h0000_0007, 32'h0000_0009, 3'b100, 0, 1, 0, 1, c0);
        wait_idle(50);
        chk("baderr_no_start", start_cnt - s0, 0);

        alu_never = 1'b1;
        send(32'd5, 32'd6, 3'b001, 1, 0, 1, 1, c0);
        wait_idle(60);
        chk("timeout_latency", rise_cyc - start_cyc, TIMEOUT + 1);
        alu_never = 1'b0;
        alu_delay = TIMEOUT;
        send(32'h7FFF_FFFF, 32'd1, 3'b100, 1, 0, 0, 1, c0);
        wait_idle(60);
        chk("done_at_limit_latency", rise_cyc - start_cyc, TIMEOUT + 1);
        alu_delay = TIMEOUT + 1;
        send(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b000, 1, 0, 1, 1, c0);
        wait_idle(60);
        repeat (3) @(posedge clk);

        fixed_ready = 1'b0; alu_delay = 1;
        x0 = xfer_cnt;
        send(32'h8000_0000, 32'h8000_0000, 3'b100, 1, 0, 0, 1, c0);
        wait_valid(30);
        repeat (5) @(negedge clk);
        @(posedge clk); #1 fixed_ready = 1'b1;
        wait_idle(30);
        chk("stall_single_xfer", xfer_cnt - x0, 1);

        alu_delay = 8;
        send(32'd3, 32'd4, 3'b000, 1, 0, 0, 1, c0);
        for (int k = 0; k < 3; k++) begin
            frm_valid = 1'b1; frm_a = $urandom;
            @(posedge clk); #1 frm_valid = 1'b0;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("drop_cnt_3", drop_cnt, 3);
        wait_idle(40);

        fixed_ready = 1'b0; alu_delay = 1;
        send(32'd9, 32'd9, 3'b101, 1, 0, 0, 1, c0);
        wait_valid(30);
        @(posedge clk); #1 frm_valid = 1'b1;
        repeat (300) @(posedge clk);
        #1 frm_valid = 1'b0;
        @(negedge clk);
        chk("drop_cnt_sat", drop_cnt, 255);
        @(posedge clk); #1 fixed_ready = 1'b1;
        wait_idle(30);

        fixed_ready = 1'b0;
        send(32'd1, 32'd1, 3'b100, 1, 0, 0, 0, c0);
        wait_valid(30);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst_pending_valid", out_valid, 0);
        chk("rst_pending_drop", drop_cnt, 0);
        @(posedge clk); #1 rst_n = 1'b1; fixed_ready = 1'b1;

        alu_never = 1'b1;
        send(32'd2, 32'd3, 3'b100, 1, 0, 0, 0, c0);
        @(posedge clk); @(posedge clk); #1;
        chk("wait_busy", busy, 1);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst_wait_busy", busy, 0);
        chk("rst_wait_valid", out_valid, 0);
        chk("rst_wait_start", alu_start, 0);
        @(posedge clk); #1 rst_n = 1'b1; alu_never = 1'b0;
        nv = 0;
        repeat (20) begin @(negedge clk); if (out_valid) nv++; end
        chk("rst_wait_no_resp", nv, 0);

        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            if (i % 4 == 0) op = 3'b100;
            if (i % 4 == 1) op = 3'b101;
            good = $urandom_range(0, 7) != 0;
            err = $urandom_range(0, 9) == 0;
            legal = (op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd5);
            nev = legal && good && !err && ($urandom_range(0, 14) == 0);
            alu_never = nev;
            alu_delay = $urandom_range(1, 6);
            send((i % 5 == 0) ? 32'hFFFF_FFFF : $urandom, (i % 7 == 0) ? 32'd0 : $urandom,
                 op, good, err, nev, 1, c0);
            wait_idle(120);
            alu_never = 1'b0;
        end
        rand_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
